// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the 1024x768@65 MHz VGA sync path.
// Lock-state encoding lives here so the bench and the decoder agree.
package vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_TOTAL  = 1344;
    localparam int V_ACTIVE = 768;
    localparam int V_TOTAL  = 806;
    localparam int CNT_W    = 11;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rise/fall pulse generator for one bit; history resets high and the
// first sample after reset is never reported as an edge.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;
    logic primed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= 1'b1;
            primed_q <= 1'b0;
        end else begin
            d_q      <= d;
            primed_q <= 1'b1;
        end
    end

    assign rise = primed_q & d & ~d_q;
    assign fall = primed_q & ~d & d_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA sync/blank stream and tracks
// whether the line and frame timing match the expected mode.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_TOTAL     = 1344,
    parameter int V_ACTIVE    = 768,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        de_out,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err
);

    import vga_pkg::*;

    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
    localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [7:0]  LOCK_W   = 8'(LOCK_FRAMES);

    logic hb_rise, hb_fall;
    logic vb_rise, vb_fall;
    logic line_start;

    logic        vblank_seen;
    logic        period_valid;
    logic [10:0] period_cnt;
    logic [10:0] run_cnt;

    logic period_err, run_err, line_err, frame_err, any_err;

    sync_state_t state;
    logic [7:0]  good_cnt;

    edge_det u_hblnk_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .d     (hblnk_in),
        .rise  (hb_rise),
        .fall  (hb_fall)
    );

    edge_det u_vblnk_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .d     (vblnk_in),
        .rise  (vb_rise),
        .fall  (vb_fall)
    );

    assign line_start = hb_fall;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out   <= '0;
            vcount_out   <= '0;
            de_out       <= 1'b0;
            rgb_out      <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            frame_start  <= 1'b0;
            vblank_seen  <= 1'b0;
            period_valid <= 1'b0;
            period_cnt   <= '0;
            run_cnt      <= '0;
        end else begin
            hcount_out  <= line_start ? '0 : sat_inc(hcount_out);
            frame_start <= 1'b0;
            if (vblnk_in) begin
                vblank_seen <= 1'b1;
            end
            if (line_start && !vblnk_in) begin
                if (vblank_seen) begin
                    vcount_out  <= '0;
                    frame_start <= 1'b1;
                    vblank_seen <= 1'b0;
                end else begin
                    vcount_out <= sat_inc(vcount_out);
                end
            end
            de_out    <= !hblnk_in && !vblnk_in;
            rgb_out   <= (!hblnk_in && !vblnk_in) ? rgb_in : 12'h000;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;

            // period_cnt equals the line length when the next line starts
            period_cnt <= line_start ? 11'd1 : sat_inc(period_cnt);
            run_cnt    <= hblnk_in ? '0 : sat_inc(run_cnt);

            if (state == SEARCH) begin
                period_valid <= 1'b0;
            end else if (line_start) begin
                period_valid <= 1'b1;
            end
        end
    end

    assign period_err = line_start && period_valid && (period_cnt != H_TOT_W);
    assign run_err    = hb_rise && (run_cnt != H_ACT_W);
    assign line_err   = period_err || run_err;
    assign frame_err  = vb_rise && (({1'b0, vcount_out} + 12'd1) != V_ACT_W);
    assign any_err    = line_err || frame_err;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            unique case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vb_fall) begin
                        state    <= ALIGN;
                        good_cnt <= '0;
                    end
                end
                ALIGN: begin
                    if (any_err) begin
                        state      <= SEARCH;
                        timing_err <= 1'b1;
                    end else if (vb_rise) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt + 8'd1 >= LOCK_W) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state      <= SEARCH;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE, default 1024, active pixels per line.
REQ-002 Parameter H_TOTAL, default 1344, pixel clocks per line.
REQ-003 Parameter V_ACTIVE, default 768, active lines per frame.
REQ-004 Parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
  - pclk  in  1  pixel clock (65 MHz); all logic on its rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - hsync_in, vsync_in  in  1 each  sync from the VGA timing stream.
  - hblnk_in, vblnk_in  in  1 each  blanking from the VGA timing stream.
  - rgb_in  in  12  pixel data {r,g,b}.
  - hcount_out, vcount_out  out  11 each  recovered pixel coordinates.
  - de_out  out  1  active-video qualifier.
  - rgb_out  out  12  pixel data aligned to coordinates.
  - hsync_out, vsync_out  out  1 each  delayed syncs.
  - frame_start  out  1  one-cycle pulse at pixel (0,0).
  - locked  out  1  timing lock indicator.
  - timing_err  out  1  one-cycle pulse on a timing violation.

Function
REQ-006 The block SHALL register all outputs; latency from any input to its corresponding output SHALL be exactly 1 pclk.
REQ-007 A line-start event SHALL be a hblnk_in 1->0 transition (previous-cycle sample 1, current 0).
REQ-008 hcount SHALL load 0 on a line-start event, otherwise increment by 1, saturating at 2047.
REQ-009 The first line-start with vblnk_in=0 after vblnk_in was 1 SHALL load vcount 0 and raise frame_start for that cycle; each later line-start with vblnk_in=0 SHALL increment vcount, saturating at 2047.
REQ-010 de_out SHALL be 1 iff hblnk_in=0 and vblnk_in=0 in the sampled cycle; rgb_out SHALL be rgb_in when de_out=1, else 12'h000.
REQ-011 A separate 11-bit period counter SHALL measure pclks between consecutive line-starts; the run length of hblnk_in=0 SHALL also be measured.
REQ-012 A line error SHALL occur if the period is not H_TOTAL or the active run is not H_ACTIVE; the period check SHALL be skipped for the first line after reset or after leaving SEARCH.
REQ-013 A frame error SHALL occur if the active-line count at the vblnk_in 0->1 transition is not V_ACTIVE.
REQ-014 FSM states SHALL be SEARCH, ALIGN and LOCKED; reset state SEARCH.
REQ-015 SEARCH->ALIGN on a vblnk_in 1->0 transition; the good-frame counter is cleared.
REQ-016 ALIGN: each error-free frame (ending at a vblnk_in 0->1 transition) SHALL increment the good-frame counter; when the count reaches LOCK_FRAMES the FSM SHALL go to LOCKED.
REQ-017 In ALIGN or LOCKED, any line or frame error SHALL pulse timing_err for 1 cycle and return the FSM to SEARCH in the next cycle.
REQ-018 locked SHALL equal 1 only in LOCKED; errors in SEARCH SHALL NOT pulse timing_err.
REQ-019 If a line error and a frame error occur in the same cycle, the block SHALL give a single timing_err pulse.
REQ-020 Coordinates SHALL be produced in all states; consumers qualify them with locked.

Reset
REQ-021 While rst_n=0, the block SHALL hold all outputs at 0, all counters at 0, edge-detect history at 1 (so no spurious edge follows reset), and the FSM in SEARCH.
REQ-022 When rst_n deasserts mid-frame, the block SHALL stay in SEARCH until the next vblnk_in 1->0 transition.

Structure
REQ-023 Shared package vga_pkg SHALL hold the 1024x768@65 MHz timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL=806) and the FSM state encoding.
REQ-024 Edge detection SHALL be a single sub-module, edge_det (rise/fall pulses for one bit), instanced for hblnk and vblnk.

Verification
REQ-025 Reset mid-frame, then drive the generator's nominal 1344x806 stream: locked rises after the 2nd complete good frame; frame_start pulses once per frame; hcount=0 and vcount=0 on that cycle.
REQ-026 Locked; check pixel (1023,767): hcount_out=1023, vcount_out=767, de_out=1, rgb_out equals rgb_in delayed 1 cycle; next cycle de_out=0, rgb_out=12'h000.
REQ-027 Locked; shorten one line period to 1343: timing_err pulses once, locked falls the next cycle, and relock occurs after 2 good frames.
REQ-028 Locked; a frame with 767 active lines: timing_err pulses at the vblnk rise and locked drops.
REQ-029 Hold hblnk_in=0 for 3000 cycles: hcount_out saturates at 2047 with no wrap; a single timing_err pulse if in ALIGN/LOCKED.
REQ-030 Assert rst_n=0 for 1 cycle while in LOCKED: all outputs are 0 immediately (asynchronously); no frame_start until the next vblnk falling edge.
